// File: rtl/aes_pkg.sv
// aes_pkg: shared definitions for the AES-128 cores (aes, aes_decrypt).
//   - SBOX / INV_SBOX byte substitution (table lookup)
//   - RCON[1..10] round constants
//   - xtime / gf_mul helpers for the MixColumns coefficients
//   - FSM state encoding shared by both iterative cores
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    ROUNDS = 2'd2
  } state_t;

  // Byte n of each table lives at bits [2047-8n -: 8].
  localparam logic [2047:0] SBOX_TAB = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX_TAB = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  // ~b * 8 maps byte b to its slice counted down from the MSB end.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = {~b, 3'b000};
    return SBOX_TAB[idx +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = {~b, 3'b000};
    return INV_SBOX_TAB[idx +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // GF(2^8) multiply by a 4-bit constant; enough for 09/0b/0d/0e and 02/03.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] c);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (c[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_decrypt_inv_round.sv
// inv_round: one combinational AES inverse round.
//   state_in  : 128-bit state, byte 0 = bits [127:120], column-major
//   round_key : round key added after InvSubBytes
//   last      : 1 = final round (InvMixColumns skipped)
//   state_out : InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state_in))))
module inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         last,
  output logic [127:0] state_out
);

  logic [7:0] t [16];
  logic [7:0] m [16];

  // Byte i sits at row i%4, column i/4. InvShiftRows rotates row r right by
  // r, so output column c takes input column (c - r) mod 4.
  for (genvar i = 0; i < 16; i++) begin : g_byte
    localparam int R   = i % 4;
    localparam int C   = i / 4;
    localparam int SRC = R + 4 * ((C - R + 4) % 4);
    assign t[i] = inv_sbox(state_in[127-8*SRC -: 8]) ^ round_key[127-8*i -: 8];
    assign state_out[127-8*i -: 8] = last ? t[i] : m[i];
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    assign m[4*c+0] = gf_mul(t[4*c], 4'he) ^ gf_mul(t[4*c+1], 4'hb) ^
                      gf_mul(t[4*c+2], 4'hd) ^ gf_mul(t[4*c+3], 4'h9);
    assign m[4*c+1] = gf_mul(t[4*c], 4'h9) ^ gf_mul(t[4*c+1], 4'he) ^
                      gf_mul(t[4*c+2], 4'hb) ^ gf_mul(t[4*c+3], 4'hd);
    assign m[4*c+2] = gf_mul(t[4*c], 4'hd) ^ gf_mul(t[4*c+1], 4'h9) ^
                      gf_mul(t[4*c+2], 4'he) ^ gf_mul(t[4*c+3], 4'hb);
    assign m[4*c+3] = gf_mul(t[4*c], 4'hb) ^ gf_mul(t[4*c+1], 4'hd) ^
                      gf_mul(t[4*c+2], 4'h9) ^ gf_mul(t[4*c+3], 4'he);
  end

endmodule

// File: rtl/aes_decrypt.sv
// aes_decrypt: iterative AES-128 inverse cipher, one round per clock.
//   clk, reset  : clock and synchronous active-high reset
//   start       : request, sampled only while idle
//   cipher_text : ciphertext, captured on accepted start
//   key         : cipher key (round key 0), captured on accepted start
//   plaintext   : result register, holds until next completion or reset
//   ready       : one-cycle pulse, plaintext valid
//   busy        : high while an operation is in progress
// Flow: 10 cycles of forward key expansion to reach K10, then 10 inverse
// rounds that walk the key schedule backwards, so no round-key storage.
module aes_decrypt
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] cipher_text,
  input  logic [127:0] key,
  output logic [127:0] plaintext,
  output logic         ready,
  output logic         busy
);

  localparam logic [3:0] NR_L = 4'(NR);

  state_t       state;
  state_t       state_nx;
  logic [3:0]   cnt;        // rc during EXPAND, r during ROUNDS
  logic [127:0] key_reg;
  logic [127:0] state_reg;  // holds ciphertext during EXPAND

  logic         ld;
  logic         do_exp;
  logic         do_rnd;
  logic         fin;
  logic [127:0] key_fwd;
  logic [127:0] key_inv;
  logic [127:0] round_out;

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] fwd_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_word(rot_word(k[31:0])) ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Undo one forward step: recover w3..w1 by pairwise XOR first, then w0
  // needs the previous key's w3, which is the freshly recovered w'3.
  function automatic logic [127:0] inv_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0] ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ sub_word(rot_word(w3)) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  assign key_fwd = fwd_expand(key_reg, rcon(cnt));
  assign key_inv = inv_expand(key_reg, rcon(4'(cnt + 4'd1)));

  inv_round u_inv_round (
    .state_in  (state_reg),
    .round_key (key_inv),
    .last      (cnt == 4'd0),
    .state_out (round_out)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; counter values outside the legal range fall back to IDLE
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:   state_nx = start ? EXPAND : IDLE;
      EXPAND: if (do_exp) state_nx = (cnt == NR_L) ? ROUNDS : EXPAND;
      ROUNDS: if (do_rnd) state_nx = (cnt == 4'd0) ? IDLE : ROUNDS;
      default: state_nx = IDLE;
    endcase
  end

  // Control decode
  always_comb begin
    ld     = (state == IDLE) && start;
    do_exp = (state == EXPAND) && (cnt >= 4'd1) && (cnt <= NR_L);
    do_rnd = (state == ROUNDS) && (cnt < NR_L);
    fin    = do_rnd && (cnt == 4'd0);
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      key_reg   <= '0;
      state_reg <= '0;
      plaintext <= '0;
      ready     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      ready <= 1'b0;
      busy  <= (state_nx != IDLE);
      if (ld) begin
        state_reg <= cipher_text;
        key_reg   <= key;
        cnt       <= 4'd1;
      end
      if (do_exp) begin
        key_reg <= key_fwd;
        if (cnt == NR_L) begin
          state_reg <= state_reg ^ key_fwd;  // initial AddRoundKey with K10
          cnt       <= NR_L - 4'd1;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end
      if (do_rnd) begin
        state_reg <= round_out;
        key_reg   <= key_inv;
        if (fin) begin
          plaintext <= round_out;
          ready     <= 1'b1;
          cnt       <= '0;
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_decrypt.sv
// tb_aes_decrypt: directed + round-trip bench for aes_decrypt. Keeps its own
// AES model (S-box derived from the GF(2^8) inverse, full key expansion) and
// a transaction-level timing model compared against the DUT every cycle.
module tb_aes_decrypt;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [127:0] cipher_text, key, plaintext;
  logic         ready, busy;

  always #5 clk = ~clk;

  aes_decrypt #(.NR(10)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .cipher_text (cipher_text),
    .key         (key),
    .plaintext   (plaintext),
    .ready       (ready),
    .busy        (busy)
  );

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;
  int rdy_cnt = 0;
  logic [7:0] sb_t [256];
  logic [7:0] isb_t [256];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference AES model ----------------
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  task automatic build_tables();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
      sb_t[x]  = s;
      isb_t[s] = 8'(x);
    end
  endtask

  function automatic logic [7:0] gb(input logic [127:0] x, input int i);
    return x[127-8*i -: 8];
  endfunction

  function automatic logic [127:0] f_shift(input logic [127:0] x, input bit inv);
    logic [127:0] y;
    int r, c, sc;
    for (int i = 0; i < 16; i++) begin
      r = i % 4; c = i / 4;
      sc = inv ? (c - r + 4) % 4 : (c + r) % 4;
      y[127-8*i -: 8] = gb(x, r + 4 * sc);
    end
    return y;
  endfunction

  function automatic logic [127:0] f_sub(input logic [127:0] x, input bit inv);
    logic [127:0] y;
    for (int i = 0; i < 16; i++)
      y[127-8*i -: 8] = inv ? isb_t[gb(x, i)] : sb_t[gb(x, i)];
    return y;
  endfunction

  function automatic logic [127:0] f_mix(input logic [127:0] x, input bit inv);
    logic [127:0] y;
    logic [7:0] cf [4];
    logic [7:0] acc;
    if (inv) begin cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09; end
    else     begin cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01; end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gm(cf[(j - r + 4) % 4], gb(x, j + 4 * c));
        y[127-8*(r+4*c) -: 8] = acc;
      end
    return y;
  endfunction

  function automatic logic [127:0] f_key(input logic [127:0] k0, input int n);
    logic [127:0] k;
    logic [31:0] t, w0, w1, w2, w3;
    logic [7:0] rc;
    k = k0; rc = 8'h01;
    for (int i = 0; i < n; i++) begin
      t  = {k[23:0], k[31:24]};
      t  = {sb_t[t[31:24]], sb_t[t[23:16]], sb_t[t[15:8]], sb_t[t[7:0]]};
      w0 = k[127:96] ^ t ^ {rc, 24'h0};
      w1 = k[95:64] ^ w0;
      w2 = k[63:32] ^ w1;
      w3 = k[31:0] ^ w2;
      k  = {w0, w1, w2, w3};
      rc = gm(rc, 8'h02);
    end
    return k;
  endfunction

  function automatic logic [127:0] enc(input logic [127:0] p, input logic [127:0] k);
    logic [127:0] s;
    s = p ^ f_key(k, 0);
    for (int r = 1; r < 10; r++)
      s = f_mix(f_shift(f_sub(s, 0), 0), 0) ^ f_key(k, r);
    return f_shift(f_sub(s, 0), 0) ^ f_key(k, 10);
  endfunction

  // Straight reversal of enc, operation by operation
  function automatic logic [127:0] dec(input logic [127:0] c, input logic [127:0] k);
    logic [127:0] s;
    s = f_sub(f_shift(c ^ f_key(k, 10), 1), 1);
    for (int r = 9; r >= 1; r--)
      s = f_sub(f_shift(f_mix(s ^ f_key(k, r), 1), 1), 1);
    return s ^ f_key(k, 0);
  endfunction

  // ---------------- transaction timing model ----------------
  logic         m_busy = 1'b0, m_ready = 1'b0;
  logic [127:0] m_pt = '0, m_ct = '0, m_key = '0;
  int           m_cnt = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 1'b0; m_ready <= 1'b0; m_pt <= '0; m_cnt <= 0;
    end else begin
      m_ready <= 1'b0;
      if (!m_busy) begin
        if (start) begin
          m_busy <= 1'b1; m_cnt <= 0; m_ct <= cipher_text; m_key <= key;
        end
      end else if (m_cnt == 19) begin
        m_busy <= 1'b0; m_ready <= 1'b1; m_pt <= dec(m_ct, m_key); m_cnt <= 0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (ready) rdy_cnt++;
    if (chk_en) begin
      chk("cyc_ready", {127'b0, ready}, {127'b0, m_ready});
      chk("cyc_busy", {127'b0, busy}, {127'b0, m_busy});
      chk("cyc_plaintext", plaintext, m_pt);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [127:0] c, input logic [127:0] k);
    cipher_text = c; key = k; start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_ready(output int lat);
    bit ok;
    ok = 0; lat = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick(1);
      lat++;
      if (ready) ok = 1;
    end
    chk("ready_seen", {127'b0, ok}, 128'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lat2, r0;
    logic [127:0] k, p, c;
    reset = 1'b1; start = 1'b0; cipher_text = '0; key = '0;

    build_tables();
    c = {120'b0, sb_t[8'h00]};
    chk("model_sbox00", c, 128'h63);
    c = {120'b0, sb_t[8'h53]};
    chk("model_sbox53", c, 128'hed);
    chk("model_enc_c1", enc(C1_PT, C1_KEY), C1_CT);
    chk("model_dec_c1", dec(C1_CT, C1_KEY), C1_PT);
    chk("model_dec_b", dec(B_CT, B_KEY), B_PT);

    tick(1);
    chk_en = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("rst_plaintext", plaintext, 128'h0);
    chk("rst_busy_ready", {126'b0, busy, ready}, 128'd0);

    // FIPS-197 C.1
    start_op(C1_CT, C1_KEY);
    chk("c1_busy", {127'b0, busy}, 128'd1);
    wait_ready(lat);
    chk("c1_latency", 128'(lat), 128'd20);
    chk("c1_pt", plaintext, C1_PT);
    tick(1);
    chk("c1_ready_width", {127'b0, ready}, 128'd0);

    // FIPS-197 B
    start_op(B_CT, B_KEY);
    wait_ready(lat);
    chk("b_latency", 128'(lat), 128'd20);
    chk("b_pt", plaintext, B_PT);
    tick(2);

    // start while busy is ignored
    start_op(C1_CT, C1_KEY);
    tick(4);
    cipher_text = B_CT; key = B_KEY; start = 1'b1;
    tick(1);
    start = 1'b0;
    r0 = rdy_cnt;
    wait_ready(lat);
    chk("busy_ign_latency", 128'(lat), 128'd15);
    chk("busy_ign_pt", plaintext, C1_PT);
    tick(25);
    chk("busy_ign_one_ready", 128'(rdy_cnt - r0), 128'd1);

    // continuous start: back-to-back at 21 cycles
    cipher_text = C1_CT; key = C1_KEY; start = 1'b1;
    tick(1);
    cipher_text = B_CT; key = B_KEY;
    wait_ready(lat);
    chk("cont_first_latency", 128'(lat), 128'd20);
    chk("cont_first_pt", plaintext, C1_PT);
    tick(1);
    start = 1'b0;
    chk("cont_pt_hold", plaintext, C1_PT);
    wait_ready(lat2);
    chk("cont_spacing", 128'(lat2 + 1), 128'd21);
    chk("cont_second_pt", plaintext, B_PT);
    tick(2);

    // reset mid-operation
    start_op(C1_CT, C1_KEY);
    tick(11);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("abort_plaintext", plaintext, 128'h0);
    chk("abort_busy_ready", {126'b0, busy, ready}, 128'd0);
    r0 = rdy_cnt;
    tick(25);
    chk("abort_no_ready", 128'(rdy_cnt - r0), 128'd0);

    // start and reset on the same edge
    cipher_text = C1_CT; key = C1_KEY; start = 1'b1; reset = 1'b1;
    tick(1);
    start = 1'b0; reset = 1'b0;
    chk("rst_wins_busy", {127'b0, busy}, 128'd0);
    tick(1);
    chk("rst_wins_still_idle", {127'b0, busy}, 128'd0);

    start_op(B_CT, B_KEY);
    wait_ready(lat);
    chk("after_abort_pt", plaintext, B_PT);
    tick(1);

    // round-trip through the bench encryptor
    for (int n = 0; n < 100; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      c = enc(p, k);
      start_op(c, k);
      wait_ready(lat);
      chk("roundtrip_pt", plaintext, p);
      tick(1);
    end

    tick(2);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
